// File: rtl/bcd_scan_if.sv
// bcd_scan_if -- bus between the display controller and the digit scanner.
//   en         scan enable
//   load       one-cycle strobe capturing value_in into the scanner's shadow
//   value_in   packed 4-bit digit codes, digit 0 (rightmost) in [3:0]
//   digit_code code of the digit currently lit, to the 7-segment decoder
//   anode_n    active-low digit enables
//   frame_done one-cycle pulse when the last digit lights
// master: controller side (drives en/load/value_in). slave: the scanner.
interface bcd_scan_if #(
  parameter int N_DIGITS = 4
);
  logic                    en;
  logic                    load;
  logic [4*N_DIGITS-1:0]   value_in;
  logic [3:0]              digit_code;
  logic [N_DIGITS-1:0]     anode_n;
  logic                    frame_done;

  modport master (output en, load, value_in,
                  input  digit_code, anode_n, frame_done);
  modport slave  (input  en, load, value_in,
                  output digit_code, anode_n, frame_done);
endinterface

// File: rtl/bcd_scan_mux.sv
// bcd_scan_mux -- time-multiplexed scanner for an N-digit common-anode
// 7-segment display. One digit is lit per refresh slot of REFRESH_DIV cycles.
// Ports:
//   clk    system clock (rising edge)
//   rst_n  asynchronous active-low reset
//   bus    bcd_scan_if.slave: en, load, value_in in; digit_code, anode_n,
//          frame_done out (all outputs registered)
// Optional build macro BCD_SCAN_LZ_BLANK_EN: leading-zero blanking. A digit
// k > 0 whose nibble and all higher nibbles are zero keeps its anode off.
// Codes A-F count as non-zero data.
module bcd_scan_mux #(
  parameter int N_DIGITS    = 4,
  parameter int REFRESH_DIV = 50000,
  parameter int CNT_W       = 20,
  parameter int IDX_W       = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  bcd_scan_if.slave   bus
);

  logic [4*N_DIGITS-1:0] r_shadow;
  logic [CNT_W-1:0]      r_presc;
  logic [IDX_W-1:0]      r_idx;
  logic [3:0]            r_code;
  logic [N_DIGITS-1:0]   r_anode_n;
  logic                  r_frame;

  logic                  w_tick;
  logic                  w_last;
  logic [3:0]            w_nibble;
  logic [N_DIGITS-1:0]   w_anode_sel;
  logic                  w_blank;

  assign w_tick = bus.en && (r_presc == CNT_W'(REFRESH_DIV - 1));
  assign w_last = (r_idx == IDX_W'(N_DIGITS - 1));

`ifdef BCD_SCAN_LZ_BLANK_EN
  // w_lz[k]: nibbles k .. N_DIGITS-1 are all zero.
  logic [N_DIGITS-1:0] w_lz;
  for (genvar k = 0; k < N_DIGITS; k++) begin : g_lz
    assign w_lz[k] = ~|r_shadow[4*N_DIGITS-1:4*k];
  end
`endif

  // Decode the current index into nibble select, anode pattern and blanking.
  always_comb begin
    w_nibble    = 4'h0;
    w_anode_sel = '1;
    w_blank     = 1'b0;
    for (int k = 0; k < N_DIGITS; k++) begin
      if (r_idx == IDX_W'(k)) begin
        w_nibble       = r_shadow[4*k +: 4];
        w_anode_sel[k] = 1'b0;
`ifdef BCD_SCAN_LZ_BLANK_EN
        w_blank        = (k != 0) && w_lz[k];
`endif
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_shadow  <= '0;
      r_presc   <= '0;
      r_idx     <= '0;
      r_code    <= 4'h0;
      r_anode_n <= '1;
      r_frame   <= 1'b0;
    end else begin
      if (bus.load) r_shadow <= bus.value_in;
      r_frame <= 1'b0;
      if (!bus.en) begin
        // Prescaler and index freeze; code holds, display goes dark.
        r_anode_n <= '1;
      end else if (w_tick) begin
        // Uses the pre-load shadow and pre-increment index on this edge.
        r_presc   <= '0;
        r_idx     <= w_last ? '0 : r_idx + 1'b1;
        r_code    <= w_nibble;
        r_anode_n <= w_blank ? '1 : w_anode_sel;
        r_frame   <= w_last;
      end else begin
        r_presc <= r_presc + 1'b1;
      end
    end
  end

  assign bus.digit_code = r_code;
  assign bus.anode_n    = r_anode_n;
  assign bus.frame_done = r_frame;

endmodule
